// File: rtl/half_adder_pkg.sv
// Shared constants and the popcount helper for the registered half adder.
package half_adder_pkg;

  localparam int              HA_WIDTH_DEFAULT = 1;
  localparam int              HA_COUNT_W       = 16;
  localparam logic [15:0]     HA_COUNT_MAX     = 16'hFFFF;

  function automatic logic [6:0] ha_popcount(input logic [63:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) begin
      n = n + {6'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// One-bit combinational half adder cell.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// Registered WIDTH-lane half adder with valid flag.
// Optional saturating carry-bit counter enabled by macro HALF_ADDER_COUNT_EN.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = HA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid
`ifdef HALF_ADDER_COUNT_EN
  ,
  output logic [HA_COUNT_W-1:0] carry_count
`endif
);

  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] carry_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .sum   (sum_next[i]),
      .carry (carry_next[i])
    );
  end

  // Result registers only load on accepted operands, so X on idle inputs never reaches them.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      carry     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= sum_next;
        carry <= carry_next;
      end
    end
  end

`ifdef HALF_ADDER_COUNT_EN
  logic [6:0]          carry_bits;
  logic [HA_COUNT_W:0] count_wide;

  assign carry_bits = ha_popcount(64'(carry_next));
  assign count_wide = {1'b0, carry_count} + {{(HA_COUNT_W-6){1'b0}}, carry_bits};

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_count <= '0;
    end else if (in_valid) begin
      if (count_wide > {1'b0, HA_COUNT_MAX}) begin
        carry_count <= HA_COUNT_MAX;
      end else begin
        carry_count <= count_wide[HA_COUNT_W-1:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_half_adder.sv
// Directed self-checking bench for half_adder at WIDTH 1, 4 and 64.
module tb_half_adder;

  logic        clk = 1'b0;
  logic        rst;

  logic        a1, b1, v1, sum1, carry1, ov1;
  logic [3:0]  a4, b4, sum4, carry4;
  logic        v4, ov4;
  logic [63:0] a64, b64, sum64, carry64;
  logic        v64, ov64;
`ifdef HALF_ADDER_COUNT_EN
  logic [15:0] cc1, cc4, cc64;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .sum(sum1), .carry(carry1), .out_valid(ov1),
    .a(a1), .b(b1), .in_valid(v1)
`ifdef HALF_ADDER_COUNT_EN
    , .carry_count(cc1)
`endif
  );

  half_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .sum(sum4), .carry(carry4), .out_valid(ov4),
    .a(a4), .b(b4), .in_valid(v4)
`ifdef HALF_ADDER_COUNT_EN
    , .carry_count(cc4)
`endif
  );

  half_adder #(.WIDTH(64)) u64 (
    .clk(clk), .rst(rst), .sum(sum64), .carry(carry64), .out_valid(ov64),
    .a(a64), .b(b64), .in_valid(v64)
`ifdef HALF_ADDER_COUNT_EN
    , .carry_count(cc64)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    a1 = 0; b1 = 0; v1 = 0;
    a4 = 0; b4 = 0; v4 = 0;
    a64 = 0; b64 = 0; v64 = 0;
    tick();
    tick();
    chk("rst_sum1", 64'(sum1), 64'd0);
    chk("rst_carry1", 64'(carry1), 64'd0);
    chk("rst_ov1", 64'(ov1), 64'd0);
    chk("rst_sum4", 64'(sum4), 64'd0);
    chk("rst_ov4", 64'(ov4), 64'd0);

    // Deassert reset with an operand already presented: it is the first one accepted.
    rst = 1'b0;
    v1 = 1; a1 = 0; b1 = 0;
    tick();
    chk("tt00_sum", 64'(sum1), 64'd0);
    chk("tt00_carry", 64'(carry1), 64'd0);
    chk("tt00_ov", 64'(ov1), 64'd1);
    a1 = 0; b1 = 1;
    tick();
    chk("tt01_sum", 64'(sum1), 64'd1);
    chk("tt01_carry", 64'(carry1), 64'd0);
    chk("tt01_ov", 64'(ov1), 64'd1);
    a1 = 1; b1 = 0;
    tick();
    chk("tt10_sum", 64'(sum1), 64'd1);
    chk("tt10_carry", 64'(carry1), 64'd0);
    chk("tt10_ov", 64'(ov1), 64'd1);
    a1 = 1; b1 = 1;
    tick();
    chk("tt11_sum", 64'(sum1), 64'd0);
    chk("tt11_carry", 64'(carry1), 64'd1);
    chk("tt11_ov", 64'(ov1), 64'd1);

    // Hold: idle for 3 cycles with toggling and X operands.
    v1 = 0;
    a1 = 0; b1 = 1;
    tick();
    chk("hold0_sum", 64'(sum1), 64'd0);
    chk("hold0_carry", 64'(carry1), 64'd1);
    chk("hold0_ov", 64'(ov1), 64'd0);
    a1 = 1'bx; b1 = 1'bx;
    tick();
    chk("hold1_sum", 64'(sum1), 64'd0);
    chk("hold1_carry", 64'(carry1), 64'd1);
    chk("hold1_ov", 64'(ov1), 64'd0);
    a1 = 1; b1 = 0;
    tick();
    chk("hold2_sum", 64'(sum1), 64'd0);
    chk("hold2_carry", 64'(carry1), 64'd1);
    chk("hold2_ov", 64'(ov1), 64'd0);

    // Four-lane vectors.
    v4 = 1; a4 = 4'b1011; b4 = 4'b0110;
    tick();
    chk("w4a_sum", 64'(sum4), 64'(4'b1101));
    chk("w4a_carry", 64'(carry4), 64'(4'b0010));
    chk("w4a_ov", 64'(ov4), 64'd1);
    a4 = 4'b1111; b4 = 4'b0000;
    tick();
    chk("w4b_sum", 64'(sum4), 64'(4'b1111));
    chk("w4b_carry", 64'(carry4), 64'(4'b0000));
    a4 = 4'b1100; b4 = 4'b1010;
    tick();
    chk("w4c_sum", 64'(sum4), 64'(4'b0110));
    chk("w4c_carry", 64'(carry4), 64'(4'b1000));
    v4 = 0;
    tick();
    chk("w4_idle_ov", 64'(ov4), 64'd0);
    chk("w4_idle_carry", 64'(carry4), 64'(4'b1000));

    // Wide lanes, including the top lane.
    v64 = 1; a64 = 64'hF0F0_0000_FFFF_0001; b64 = 64'h8F0F_0000_00FF_0003;
    tick();
    chk("w64_sum", sum64, 64'h7FFF_0000_FF00_0002);
    chk("w64_carry", carry64, 64'h8000_0000_00FF_0001);
    v64 = 0;

    // Reset colliding with a valid operand.
    rst = 1; v1 = 1; a1 = 1; b1 = 1;
    tick();
    chk("coll_sum", 64'(sum1), 64'd0);
    chk("coll_carry", 64'(carry1), 64'd0);
    chk("coll_ov", 64'(ov1), 64'd0);
    chk("coll_carry4", 64'(carry4), 64'd0);
    chk("coll_carry64", carry64, 64'd0);
    rst = 0; a1 = 1; b1 = 0;
    tick();
    chk("post_sum", 64'(sum1), 64'd1);
    chk("post_carry", 64'(carry1), 64'd0);
    chk("post_ov", 64'(ov1), 64'd1);
    v1 = 0;

`ifdef HALF_ADDER_COUNT_EN
    // Counter: 3 x 4 carry bits.
    rst = 1;
    tick();
    chk("cnt_rst", 64'(cc4), 64'd0);
    rst = 0; v4 = 1; a4 = 4'hF; b4 = 4'hF;
    tick();
    tick();
    tick();
    chk("cnt_12", 64'(cc4), 64'd12);
    v4 = 0; a4 = 4'hF;
    tick();
    chk("cnt_idle", 64'(cc4), 64'd12);
    a4 = 4'b0011; b4 = 4'b0001; v4 = 1;
    tick();
    chk("cnt_13", 64'(cc4), 64'd13);
    v4 = 0;

    // Saturation: 64 bits per accept, 1023 accepts = 65472, next would be 65536.
    v64 = 1; a64 = '1; b64 = '1;
    for (int i = 0; i < 1023; i++) tick();
    chk("cnt_near", 64'(cc64), 64'd65472);
    tick();
    chk("cnt_sat", 64'(cc64), 64'hFFFF);
    tick();
    chk("cnt_sat_hold", 64'(cc64), 64'hFFFF);
    v64 = 0;
    rst = 1;
    tick();
    chk("cnt_rst2", 64'(cc64), 64'd0);
    rst = 0;
`endif

    // Reset from an arbitrary running state.
    v4 = 1; a4 = 4'b0111; b4 = 4'b0101;
    tick();
    chk("run_sum4", 64'(sum4), 64'(4'b0010));
    chk("run_carry4", 64'(carry4), 64'(4'b0101));
    rst = 1;
    tick();
    chk("any_rst_sum4", 64'(sum4), 64'd0);
    chk("any_rst_carry4", 64'(carry4), 64'd0);
    chk("any_rst_ov4", 64'(ov4), 64'd0);
    rst = 0; v4 = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
